// File: rtl/rsb_pkg.sv
// rsb_pkg: shared types and constants for the rsb_64bit_seq subtract-with-borrow unit.
//   state_t    : controller states (IDLE, RUN, DONE)
//   DEF_WIDTH  : default operand/result width
//   DEF_CHUNK  : default slice width processed per clock
//   DEF_NSLICE : default number of slices (DEF_WIDTH / DEF_CHUNK)
//   cnt_width(): width of a slice counter for a given slice count
// Optional feature macro used by this unit: RSB_OVF_FLAG_EN (signed overflow flag).
package rsb_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_CHUNK  = 16;
  localparam int DEF_NSLICE = DEF_WIDTH / DEF_CHUNK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-slice configuration still needs a one-bit counter so that
  // the counter declaration stays legal.
  function automatic int cnt_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/rsb_64bit_seq_if.sv
// rsb_64bit_seq_if: operand/result handshake bundle for rsb_64bit_seq.
//   in_valid/in_ready   : operand handshake (a, b, bin)
//   out_valid/out_ready : result handshake (diff, bout, and ovf when enabled)
//   master modport      : producer of operands / consumer of results
//   slave modport       : the subtract unit itself
// Macro RSB_OVF_FLAG_EN adds the ovf signal to the bundle and both modports.
interface rsb_64bit_seq_if
  import rsb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef RSB_OVF_FLAG_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
`ifdef RSB_OVF_FLAG_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
`ifdef RSB_OVF_FLAG_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/rsb_chunk.sv
// rsb_chunk: combinational W-bit subtract-with-borrow slice.
//   x  : minuend slice
//   y  : subtrahend slice
//   bi : borrow-in
//   d  : (x - y - bi) mod 2^W
//   bo : borrow-out, 1 iff x < y + bi
module rsb_chunk #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bi,
  output logic [W-1:0] d,
  output logic         bo
);

  // One extra bit: the difference of two zero-extended W-bit values lies in
  // (-2^W, 2^W), so the top bit of the (W+1)-bit result is exactly the borrow.
  logic [W:0] full;

  assign full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
  assign d    = full[W-1:0];
  assign bo   = full[W];

endmodule

// File: rtl/rsb_64bit_seq.sv
// rsb_64bit_seq: multi-cycle subtract-with-borrow, diff = a - b - bin.
// One CHUNK-bit slice is processed per clock, LSB slice first, with the borrow
// carried between slices in a register; a single rsb_chunk is time-shared.
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous active-high reset, aborts any operation
//   bus      : rsb_64bit_seq_if.slave (in_valid/in_ready, a, b, bin,
//              out_valid/out_ready, diff, bout[, ovf])
// Macro RSB_OVF_FLAG_EN: when defined, bus.ovf carries the two's-complement
// overflow of the subtraction, registered together with bout.
// WIDTH must be a multiple of CHUNK.
module rsb_64bit_seq
  import rsb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input logic            clk,
  input logic            rst,
  rsb_64bit_seq_if.slave bus
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CNT_W  = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  state_t           state_reg;
  state_t           state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             borrow_reg;
  logic             bout_reg;
  logic [CHUNK-1:0] diff_slices_reg [NSLICE];
`ifdef RSB_OVF_FLAG_EN
  logic             ovf_reg;
`endif

  logic [CHUNK-1:0] a_slices [NSLICE];
  logic [CHUNK-1:0] b_slices [NSLICE];
  logic [CHUNK-1:0] chunk_d;
  logic             chunk_bo;
  logic             is_last;

  // Slice views of the captured operands and reassembly of the result.
  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_slices[gi]                 = a_reg[gi*CHUNK +: CHUNK];
      assign b_slices[gi]                 = b_reg[gi*CHUNK +: CHUNK];
      assign bus.diff[gi*CHUNK +: CHUNK]  = diff_slices_reg[gi];
    end
  endgenerate

  rsb_chunk #(
    .W (CHUNK)
  ) u_chunk (
    .x  (a_slices[cnt_reg]),
    .y  (b_slices[cnt_reg]),
    .bi (borrow_reg),
    .d  (chunk_d),
    .bo (chunk_bo)
  );

  assign is_last = (cnt_reg == LAST_SLICE);

  // Handshake outputs are pure state decodes, so they take their reset
  // values the same edge the state does.
  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.bout      = bout_reg;
`ifdef RSB_OVF_FLAG_EN
  assign bus.ovf       = ovf_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (is_last)       state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      cnt_reg    <= '0;
      borrow_reg <= 1'b0;
      bout_reg   <= 1'b0;
      for (int i = 0; i < NSLICE; i++) begin
        diff_slices_reg[i] <= '0;
      end
`ifdef RSB_OVF_FLAG_EN
      ovf_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          // Operands are sampled only here; later input changes are ignored.
          if (bus.in_valid) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            borrow_reg <= bus.bin;
            cnt_reg    <= '0;
          end
        end
        RUN: begin
          diff_slices_reg[cnt_reg] <= chunk_d;
          borrow_reg               <= chunk_bo;
          if (is_last) begin
            cnt_reg  <= '0;
            bout_reg <= chunk_bo;
`ifdef RSB_OVF_FLAG_EN
            // Overflow: operand signs differ and the result sign differs
            // from the minuend; the result MSB is the MSB of the last slice.
            ovf_reg  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                        (chunk_d[CHUNK-1] != a_reg[WIDTH-1]);
`endif
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsb_64bit_seq.sv
// tb_rsb_64bit_seq: self-checking bench for rsb_64bit_seq.
// Table-driven directed vectors, randomized operands against an arithmetic
// reference model, and hand-written backpressure / mid-operation reset
// sequences. Define RSB_OVF_FLAG_EN to also check the ovf output.
module tb_rsb_64bit_seq;

  localparam int NSLICE = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  rsb_64bit_seq_if bus ();

  rsb_64bit_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] d;
    logic        bo;
    logic        ov;
    string       nm;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Reference model: plain modular arithmetic and an unsigned comparison.
  task automatic model(input logic [63:0] ma, input logic [63:0] mb, input logic mbin,
                       output logic [63:0] md, output logic mbo, output logic mov);
    logic [64:0] rhs;
    md  = ma - mb - 64'(mbin);
    rhs = {1'b0, mb} + 65'(mbin);
    mbo = ({1'b0, ma} < rhs);
    mov = (ma[63] != mb[63]) && (md[63] != ma[63]);
  endtask

  // One complete operation: accept, measure latency, check result, drain.
  task automatic do_op(input string nm, input logic [63:0] ta, input logic [63:0] tb_v,
                       input logic tbin, input logic [63:0] ed, input logic eb,
                       input logic eo);
    int w;
    int lat;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk({nm, "/in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.a        = ta;
    bus.b        = tb_v;
    bus.bin      = tbin;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble the inputs: the unit must use only what it sampled at accept.
    bus.in_valid = 1'b0;
    bus.a        = {$urandom, $urandom};
    bus.b        = {$urandom, $urandom};
    bus.bin      = 1'($urandom);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({nm, "/latency"}, 64'(lat), 64'(NSLICE));
    chk({nm, "/diff"}, bus.diff, ed);
    chk({nm, "/bout"}, 64'(bus.bout), 64'(eb));
`ifdef RSB_OVF_FLAG_EN
    chk({nm, "/ovf"}, 64'(bus.ovf), 64'(eo));
`endif
    chk({nm, "/roundtrip"}, bus.diff + tb_v + 64'(tbin), ta);
    $display("txn %s a=%h b=%h bin=%0d diff=%h bout=%0d exp_ovf=%0d lat=%0d",
             nm, ta, tb_v, tbin, bus.diff, bus.bout, eo, lat);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({nm, "/out_valid_clr"}, 64'(bus.out_valid), 64'd0);
    chk({nm, "/in_ready_back"}, 64'(bus.in_ready), 64'd1);
    chk({nm, "/diff_hold"}, bus.diff, ed);
  endtask

  initial begin
    logic [63:0] ra, rb, rd;
    logic        rbin, rbo, rov;
    int          xfers;
    int          busy;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{64'd45, 64'd35, 1'b0, 64'd10, 1'b0, 1'b0, "v45_35"};
    vecs[1] = '{64'd156, 64'd132, 1'b1, 64'd23, 1'b0, 1'b0, "v156_132_b"};
    vecs[2] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, "v0_1"};
    vecs[3] = '{64'd6223410738239568193, 64'd38701384792384, 1'b1,
                64'd6223372036854775808, 1'b0, 1'b0, "vbig"};
    vecs[4] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, "v0_0_b"};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, "vovf"};
    vecs[6] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, "v5_3"};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, "vones_b"};
    vecs[8] = '{64'h0001_0000_0000_0000, 64'd1, 1'b0,
                64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, "vprop"};
    vecs[9] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'h8000_0000_0000_0000, 1'b1, 1'b1, "vovf_neg"};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst/out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst/diff", bus.diff, 64'd0);
    chk("rst/bout", 64'(bus.bout), 64'd0);
`ifdef RSB_OVF_FLAG_EN
    chk("rst/ovf", 64'(bus.ovf), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, vecs[i].ov);
    end

    for (int i = 0; i < 24; i++) begin
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      rbin = 1'($urandom);
      // Matching upper slices force borrows to ripple across slice boundaries.
      if (i % 3 == 0) rb[63:16] = ra[63:16];
      if (i % 5 == 0) rb[63:32] = ra[63:32];
      model(ra, rb, rbin, rd, rbo, rov);
      do_op($sformatf("rand%0d", i), ra, rb, rbin, rd, rbo, rov);
    end

    // Backpressure: result must hold while out_ready stays low.
    bus.a        = 64'd1000;
    bus.b        = 64'd1;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    busy = 0;
    while (bus.out_valid !== 1'b1 && busy < 20) begin
      @(posedge clk); #1; busy++;
    end
    chk("bp/latency", 64'(busy), 64'(NSLICE));
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (c % 2 == 0);
      bus.a        = {$urandom, $urandom};
      bus.b        = {$urandom, $urandom};
      @(posedge clk); #1;
      chk($sformatf("bp/out_valid%0d", c), 64'(bus.out_valid), 64'd1);
      chk($sformatf("bp/in_ready%0d", c), 64'(bus.in_ready), 64'd0);
      chk($sformatf("bp/diff%0d", c), bus.diff, 64'd999);
      chk($sformatf("bp/bout%0d", c), 64'(bus.bout), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    xfers = 0;
    busy  = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid === 1'b1) xfers++;
      if (bus.in_ready !== 1'b1) busy++;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    chk("bp/transfers", 64'(xfers), 64'd1);
    chk("bp/busy_cycles", 64'(busy), 64'd1);
    chk("bp/diff_after", bus.diff, 64'd999);
    $display("txn backpressure diff=%h transfers=%0d", bus.diff, xfers);

    // Leave a nonzero result and bout=1 so the reset check is meaningful.
    do_op("pre_rst", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

    // Reset during the second RUN cycle.
    bus.a        = 64'd13500;
    bus.b        = 64'd9654;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst/in_ready", 64'(bus.in_ready), 64'd1);
    chk("mrst/out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst/diff", bus.diff, 64'd0);
    chk("mrst/bout", 64'(bus.bout), 64'd0);
    xfers = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) xfers++;
    end
    chk("mrst/no_result", 64'(xfers), 64'd0);
    $display("txn midrun_reset out_valid_pulses=%0d", xfers);

    do_op("post_rst", 64'd13500, 64'd9654, 1'b0, 64'd3846, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
